// File: rtl/piso_feeder_if.sv
// piso_feeder_if: parallel load handshake plus serial output bundle
interface piso_feeder_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0] data_in;
    logic            load_valid;
    logic            load_ready;
    logic            stall;
    logic            serial_out;
    logic            serial_valid;
    logic            frame_start;
    logic            done;
    logic            busy;

    modport master (
        output data_in, load_valid, stall,
        input  load_ready, serial_out, serial_valid, frame_start, done, busy
    );

    modport slave (
        input  data_in, load_valid, stall,
        output load_ready, serial_out, serial_valid, frame_start, done, busy
    );
endinterface

// File: rtl/piso_feeder.sv
// piso_feeder: one-word buffered parallel-in serial-out feeder with stall and framing pulses
module piso_feeder #(
    parameter int SIZE      = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic          clk,
    input logic          reset,
    piso_feeder_if.slave bus
);
    localparam int CW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(SIZE);
    localparam logic [CW-1:0] PEN  = CW'(SIZE - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_n;
    logic [SIZE-1:0] hold_reg, shift_reg, shift_n, src, rest;
    logic [CW-1:0]   bit_count, count_n;
    logic            hold_full, hold_full_n, load_ready, accept, take, head;
    logic            serial_out, out_n, serial_valid, valid_n, frame_start, fs_n, done, done_n;

    assign accept      = bus.load_valid && load_ready;
    assign take        = hold_full && (state == IDLE || (!bus.stall && bit_count == LAST));
    assign hold_full_n = accept || (hold_full && !take);
    assign src         = take ? hold_reg : shift_reg;
    assign head        = MSB_FIRST ? src[SIZE-1] : src[0];
    assign rest        = MSB_FIRST ? {src[SIZE-2:0], 1'b0} : {1'b0, src[SIZE-1:1]};

    assign bus.load_ready   = load_ready;
    assign bus.serial_out   = serial_out;
    assign bus.serial_valid = serial_valid;
    assign bus.frame_start  = frame_start;
    assign bus.done         = done;
    assign bus.busy         = (state == SHIFT);

    // hold buffer: ready is registered so load_valid never reaches load_ready combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full  <= 1'b0;
            load_ready <= 1'b1;
            hold_reg   <= '0;
        end else begin
            hold_full  <= hold_full_n;
            load_ready <= !hold_full_n;
            if (accept) hold_reg <= bus.data_in;
        end
    end

    // next word start, bit advance, stall hold and return to idle
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        count_n = bit_count;
        out_n   = serial_out;
        valid_n = serial_valid;
        fs_n    = 1'b0;
        done_n  = 1'b0;
        if (take) begin
            state_n = SHIFT;
            out_n   = head;
            shift_n = rest;
            count_n = CW'(1);
            valid_n = 1'b1;
            fs_n    = 1'b1;
        end else if (state == SHIFT && bus.stall) begin
            valid_n = 1'b0;
        end else if (state == SHIFT && bit_count != LAST) begin
            out_n   = head;
            shift_n = rest;
            count_n = bit_count + 1'b1;
            valid_n = 1'b1;
            done_n  = (bit_count == PEN);
        end else if (state == SHIFT) begin
            state_n = IDLE;
            count_n = '0;
            out_n   = 1'b0;
            valid_n = 1'b0;
        end
    end

    // state and serial output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_count    <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            shift_reg    <= shift_n;
            bit_count    <= count_n;
            serial_out   <= out_n;
            serial_valid <= valid_n;
            frame_start  <= fs_n;
            done         <= done_n;
        end
    end
endmodule

// File: tb/tb_piso_feeder.sv
// tb_piso_feeder: word-queue scoreboard for MSB-first and LSB-first feeders with loopback reassembly
module tb_piso_feeder;
    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [SIZE-1:0] data_in = '0;
    logic            load_valid = 1'b0;
    logic            stall = 1'b0;
    logic            rnd_stall = 1'b0;
    int              tests = 0;
    int              fails = 0;
    int              sent = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam bit MSB = (g == 0);
        piso_feeder_if #(.SIZE(SIZE)) bus ();
        assign bus.data_in    = data_in;
        assign bus.load_valid = load_valid;
        assign bus.stall      = stall;
        piso_feeder #(.SIZE(SIZE), .MSB_FIRST(MSB)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

        logic [SIZE-1:0] exp_q [$];
        logic [SIZE-1:0] sr = '0;
        logic [SIZE-1:0] w;
        logic            eb;
        logic            pv = 1'b0;
        logic            pb = 1'b0;
        int              k = 0, pn = 0, v_cnt = 0, fall_cnt = 0, done_cnt = 0;

        // each valid bit is consumed at the next edge, so sample mid-cycle
        always @(negedge clk) begin
            if (reset) begin
                k  = 0;
                pv = 1'b0;
                pb = 1'b0;
                pn = 0;
            end else begin
                if (pb && stall) check(MSB ? "msb stall_valid" : "lsb stall_valid", bus.serial_valid, 0);
                if (pv && !stall && pn > 0) check(MSB ? "msb no_gap" : "lsb no_gap", bus.serial_valid, 1);
                if (pv && !bus.serial_valid) fall_cnt++;
                if (bus.serial_valid) begin
                    v_cnt++;
                    if (exp_q.size() == 0) begin
                        check(MSB ? "msb spurious_bit" : "lsb spurious_bit", bus.serial_valid, 0);
                    end else begin
                        w  = exp_q[0];
                        eb = MSB ? w[SIZE-1-k] : w[k];
                        check(MSB ? "msb bit" : "lsb bit", bus.serial_out, eb);
                        check(MSB ? "msb frame_start" : "lsb frame_start", bus.frame_start, k == 0);
                        check(MSB ? "msb done" : "lsb done", bus.done, k == SIZE - 1);
                        sr = MSB ? {sr[SIZE-2:0], bus.serial_out} : {bus.serial_out, sr[SIZE-1:1]};
                        k++;
                        if (k == SIZE) begin
                            check(MSB ? "msb loopback" : "lsb loopback", sr, w);
                            void'(exp_q.pop_front());
                            k = 0;
                            done_cnt++;
                        end
                    end
                end else begin
                    check(MSB ? "msb idle_pulses" : "lsb idle_pulses", {bus.frame_start, bus.done}, 0);
                end
                pv = bus.serial_valid;
                pb = bus.busy;
                pn = exp_q.size();
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (rnd_stall) stall = ($urandom_range(3) == 0);
    endtask

    task automatic clr();
        mon[0].v_cnt = 0; mon[0].fall_cnt = 0; mon[0].done_cnt = 0;
        mon[1].v_cnt = 0; mon[1].fall_cnt = 0; mon[1].done_cnt = 0;
    endtask

    task automatic send(input logic [SIZE-1:0] wd);
        bit ok = 1'b0;
        data_in    = wd;
        load_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (mon[0].bus.load_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            mon[0].exp_q.push_back(wd);
            mon[1].exp_q.push_back(wd);
            sent++;
        end else begin
            check("send_ready", mon[0].bus.load_ready, 1);
        end
        tick();
        load_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (mon[0].exp_q.size() == 0 && mon[1].exp_q.size() == 0 &&
                !mon[0].bus.busy && !mon[1].bus.busy && !mon[0].bus.serial_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("drain_queue", mon[0].exp_q.size(), 0);
    endtask

    task automatic check_counts(input string nm, input int v, input int f, input int d);
        check({nm, " valid_bits"}, mon[0].v_cnt, v);
        check({nm, " gaps"}, mon[0].fall_cnt, f);
        check({nm, " done_count"}, mon[0].done_cnt, d);
        check({nm, " lsb valid_bits"}, mon[1].v_cnt, v);
    endtask

    logic o;

    initial begin
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_outs", i == 0 ?
                {mon[0].bus.serial_out, mon[0].bus.serial_valid, mon[0].bus.frame_start, mon[0].bus.done, mon[0].bus.busy} :
                {mon[1].bus.serial_out, mon[1].bus.serial_valid, mon[1].bus.frame_start, mon[1].bus.done, mon[1].bus.busy}, 0);
        end
        check("reset_ready", {mon[0].bus.load_ready, mon[1].bus.load_ready}, 2'b11);
        tick();
        tick();
        reset = 1'b0;
        tick();

        clr();
        send(8'hA5);
        check("t1_latency_wait", {mon[0].bus.serial_valid, mon[0].bus.load_ready}, 2'b00);
        tick();
        check("t1_first_bit", {mon[0].bus.serial_valid, mon[0].bus.frame_start, mon[0].bus.serial_out}, 3'b111);
        drain();
        check_counts("t1", 8, 1, 1);

        clr();
        send(8'h01);
        tick();
        check("t5_first_lsb", mon[1].bus.serial_out, 1);
        check("t5_first_msb", mon[0].bus.serial_out, 0);
        drain();
        check("t5_loopback", mon[1].sr, 8'h01);
        check("t5_done_count", mon[1].done_cnt, 1);

        clr();
        send(8'hFF);
        check("t2_ready_full", mon[0].bus.load_ready, 0);
        send(8'h00);
        drain();
        check_counts("t2", 16, 1, 2);

        clr();
        send(8'hC3);
        for (int n = 0; n < 40 && mon[0].k != 3; n++) tick();
        check("t3_reach_bit3", mon[0].k, 3);
        stall = 1'b1;
        o = mon[0].bus.serial_out;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("t3_stalled", {mon[0].bus.serial_valid, mon[0].bus.serial_out}, {1'b0, o});
        end
        stall = 1'b0;
        drain();
        check_counts("t3", 8, 2, 1);

        clr();
        send(8'h3C);
        send(8'h81);
        for (int n = 0; n < 40 && mon[0].k != 4; n++) tick();
        check("t4_reach_bit4", mon[0].k, 4);
        check("t4_buffered", mon[0].bus.load_ready, 0);
        #3 reset = 1'b1;
        #1;
        check("t4_reset_outs",
            {mon[0].bus.serial_out, mon[0].bus.serial_valid, mon[0].bus.frame_start, mon[0].bus.done, mon[0].bus.busy,
             mon[1].bus.serial_out, mon[1].bus.serial_valid, mon[1].bus.frame_start, mon[1].bus.done, mon[1].bus.busy}, 0);
        check("t4_reset_ready", {mon[0].bus.load_ready, mon[1].bus.load_ready}, 2'b11);
        mon[0].exp_q.delete();
        mon[1].exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        clr();
        for (int n = 0; n < 20; n++) tick();
        check("t4_no_bits_msb", mon[0].v_cnt, 0);
        check("t4_no_bits_lsb", mon[1].v_cnt, 0);

        clr();
        sent = 0;
        rnd_stall = 1'b1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(3) == 0) begin
                for (int n = $urandom_range(4); n > 0; n--) tick();
            end
            send(SIZE'($urandom));
        end
        rnd_stall = 1'b0;
        stall = 1'b0;
        drain();
        check("rand_words_msb", mon[0].done_cnt, sent);
        check("rand_words_lsb", mon[1].done_cnt, sent);
        check("rand_bits", mon[0].v_cnt, sent * SIZE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
